vram_sync_scheduler: RTL and testbench

Sequences a bank of `sync_writer` instances, one per VRAM region (pattern, tile, sprite, palette), so that CPU-side shadow memories are copied into PPU-side memories only during vertical blank, one region at a time. The CPU posts per-channel sync requests at any time; the scheduler latches them, snapshots them at `vblank_start`, and runs each requested channel's sync handshake in fixed priority order. Sits between the CPU register interface, the PPU timing generator and the `sync_writer` bank.

---
 rtl/vram_sync_pkg.sv | 24 ++
 rtl/sync_ch_pick.sv | 21 ++
 rtl/vram_sync_scheduler.sv | 140 ++++++++++++++
 tb/tb_vram_sync_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_sync_pkg.sv
// Shared types and constants for the VRAM sync scheduler.
package vram_sync_pkg;

   localparam int VRAM_SYNC_NUM_CH = 4;

   localparam int CH_PATTERN = 0;
   localparam int CH_TILE    = 1;
   localparam int CH_SPRITE  = 2;
   localparam int CH_PALETTE = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SELECT = 3'd1,
      START  = 3'd2,
      WAIT   = 3'd3,
      CLEAR  = 3'd4
   } sync_state_e;

   // Channel index width, kept at least one bit for single-channel builds.
   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_ch_pick.sv
// Lowest-set-bit priority encoder used to pick the next channel to service.
module sync_ch_pick
   import vram_sync_pkg::*;
#(
   parameter int NUM_CH = VRAM_SYNC_NUM_CH,
   parameter int CW     = ch_idx_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   output logic [CW-1:0]     idx,
   output logic              valid
);

   always_comb begin
      idx   = '0;
      valid = |req;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req[i]) idx = CW'(i);
      end
   end

endmodule

// File: rtl/vram_sync_scheduler.sv
// Runs sync_writer handshakes one channel at a time during vertical blank.
// Optional per-channel watchdog enabled by defining VRAM_SYNC_WATCHDOG_EN.
//
// state  | meaning
// IDLE   | waiting for vblank_start with requests pending
// SELECT | pick lowest snapshotted channel, or finish the frame
// START  | one-cycle sync pulse to the selected writer
// WAIT   | waiting for the writer's done (first cycle ignored)
// CLEAR  | clear writer done, acknowledge, retire channel
module vram_sync_scheduler
   import vram_sync_pkg::*;
#(
   parameter int NUM_CH  = VRAM_SYNC_NUM_CH,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vblank_start,
   input  logic [NUM_CH-1:0] sync_req,
   output logic [NUM_CH-1:0] pending,
   output logic [NUM_CH-1:0] sw_sync,
   input  logic [NUM_CH-1:0] sw_done,
   output logic [NUM_CH-1:0] sw_clr_done,
   output logic [NUM_CH-1:0] src_lock,
   output logic [NUM_CH-1:0] sync_ack,
   output logic              busy,
   output logic              frame_done,
   output logic              overrun
`ifdef VRAM_SYNC_WATCHDOG_EN
   ,
   output logic [NUM_CH-1:0] timeout_err,
   input  logic [NUM_CH-1:0] err_clr
`endif
);

   localparam int CW = ch_idx_w(NUM_CH);

   sync_state_e       state;
   logic [NUM_CH-1:0] snapshot;
   logic [CW-1:0]     cur_ch;
   logic [CW-1:0]     pick_idx;
   logic              pick_valid;
   logic              wait_first;
   logic              snap_take;
   logic              done_seen;
   logic              wait_exit;
   logic              timed_out;
   logic [NUM_CH-1:0] ch_onehot;

   sync_ch_pick #(.NUM_CH(NUM_CH), .CW(CW)) u_pick (
      .req   (snapshot),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign ch_onehot = NUM_CH'(1) << cur_ch;
   assign snap_take = (state == IDLE) && vblank_start && (|pending);
   assign done_seen = !wait_first && sw_done[cur_ch];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         snapshot   <= '0;
         pending    <= '0;
         cur_ch     <= '0;
         wait_first <= 1'b0;
      end else begin
         // A request landing on the snapshot edge belongs to the next frame.
         pending <= snap_take ? sync_req : (pending | sync_req);
         case (state)
            IDLE: begin
               if (snap_take) begin
                  snapshot <= pending;
                  state    <= SELECT;
               end
            end
            SELECT: begin
               if (pick_valid) begin
                  cur_ch <= pick_idx;
                  state  <= START;
               end else begin
                  state <= IDLE;
               end
            end
            START: begin
               wait_first <= 1'b1;
               state      <= WAIT;
            end
            WAIT: begin
               wait_first <= 1'b0;
               if (wait_exit) state <= CLEAR;
            end
            CLEAR: begin
               snapshot <= snapshot & ~ch_onehot;
               state    <= SELECT;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef VRAM_SYNC_WATCHDOG_EN
   localparam int WW = $clog2(TIMEOUT + 1);

   logic [WW-1:0] wd_cnt;
   logic          wd_hit;
   logic          timed_out_q;

   assign wd_hit    = (wd_cnt == WW'(TIMEOUT - 1));
   assign wait_exit = done_seen || wd_hit;
   assign timed_out = timed_out_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt      <= '0;
         timed_out_q <= 1'b0;
         timeout_err <= '0;
      end else begin
         if (state == START) wd_cnt <= '0;
         else if (state == WAIT) wd_cnt <= wd_cnt + WW'(1);
         // A done arriving on the final watchdog cycle still counts as success.
         if (state == WAIT) timed_out_q <= wd_hit && !done_seen;
         timeout_err <= (timeout_err & ~err_clr)
                      | (((state == CLEAR) && timed_out_q) ? ch_onehot : '0);
      end
   end
`else
   assign wait_exit = done_seen;
   assign timed_out = 1'b0;
`endif

   assign sw_sync     = (state == START) ? ch_onehot : '0;
   assign src_lock    = ((state == START) || (state == WAIT) || (state == CLEAR)) ? ch_onehot : '0;
   assign sw_clr_done = (state == CLEAR) ? ch_onehot : '0;
   assign sync_ack    = ((state == CLEAR) && !timed_out) ? ch_onehot : '0;
   assign frame_done  = (state == SELECT) && !pick_valid;
   assign busy        = (state != IDLE) && !frame_done;
   assign overrun     = vblank_start && (state != IDLE);

endmodule

// File: tb/tb_vram_sync_scheduler.sv
// Scoreboard bench for vram_sync_scheduler; expected events are queued by the stimulus
// and a monitor pops them whenever the DUT shows an output event.
module tb_vram_sync_scheduler;
   import vram_sync_pkg::*;

   localparam int K_SYNC  = 0;
   localparam int K_ACK   = 1;
   localparam int K_CLR   = 2;
   localparam int K_FRAME = 3;
   localparam int K_OVR   = 4;
   localparam int K_LOCK  = 5;
   localparam int K_BUSY  = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic       vblank_start;
   logic [3:0] sync_req, pending, sw_sync, sw_done, sw_clr_done, src_lock, sync_ack;
   logic       busy, frame_done, overrun;
`ifdef VRAM_SYNC_WATCHDOG_EN
   logic [3:0] timeout_err, err_clr;
`endif

   vram_sync_scheduler #(.NUM_CH(4), .TIMEOUT(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .vblank_start (vblank_start),
      .sync_req     (sync_req),
      .pending      (pending),
      .sw_sync      (sw_sync),
      .sw_done      (sw_done),
      .sw_clr_done  (sw_clr_done),
      .src_lock     (src_lock),
      .sync_ack     (sync_ack),
      .busy         (busy),
      .frame_done   (frame_done),
      .overrun      (overrun)
`ifdef VRAM_SYNC_WATCHDOG_EN
      ,
      .timeout_err  (timeout_err),
      .err_clr      (err_clr)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int       cyc;
      int       kind;
      logic [3:0] val;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   function automatic string kname(input int k);
      case (k)
         K_SYNC:  return "sw_sync";
         K_ACK:   return "sync_ack";
         K_CLR:   return "sw_clr_done";
         K_FRAME: return "frame_done";
         K_OVR:   return "overrun";
         K_LOCK:  return "src_lock";
         default: return "busy";
      endcase
   endfunction

   // Keep the queue ordered by cycle, then by the order the monitor scans outputs.
   task automatic push(input int c, input int k, input logic [3:0] v);
      ev_t e;
      int  i;
      e.cyc  = c;
      e.kind = k;
      e.val  = v;
      i = 0;
      while (i < exp_q.size() &&
             (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].kind <= k))) i++;
      exp_q.insert(i, e);
   endtask

   // Expected timeline for one frame with done arriving 10 cycles after each sync.
   task automatic expect_frame(input int t, input logic [3:0] snap);
      int         c;
      logic [3:0] oh;
      c = t + 1;
      push(c, K_BUSY, 4'b0001);
      for (int i = 0; i < 4; i++) begin
         if (snap[i]) begin
            oh = 4'b0001 << i;
            push(c + 1, K_SYNC, oh);
            push(c + 1, K_LOCK, oh);
            push(c + 12, K_ACK, oh);
            push(c + 12, K_CLR, oh);
            c = c + 13;
            push(c, K_LOCK, 4'b0000);
         end
      end
      push(c, K_FRAME, 4'b0001);
      push(c, K_BUSY, 4'b0000);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic observe(input int k, input logic [3:0] v);
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected %s: got %b at cycle %0d, required no event", kname(k), v, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.cyc != cyc || e.kind != k || e.val != v) begin
            n_bad++;
            $display("FAIL event: got %s=%b at cycle %0d, required %s=%b at cycle %0d",
                     kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
         end
      end
   endtask

   // Monitor
   logic [3:0] prev_lock = 4'b0000;
   logic       prev_busy = 1'b0;
   initial begin
      forever begin
         @(negedge clk);
         if (sw_sync != 4'b0000)     observe(K_SYNC, sw_sync);
         if (sync_ack != 4'b0000)    observe(K_ACK, sync_ack);
         if (sw_clr_done != 4'b0000) observe(K_CLR, sw_clr_done);
         if (frame_done)             observe(K_FRAME, 4'b0001);
         if (overrun)                observe(K_OVR, 4'b0001);
         if (src_lock != prev_lock)  observe(K_LOCK, src_lock);
         if (busy != prev_busy)      observe(K_BUSY, {3'b000, busy});
         prev_lock = src_lock;
         prev_busy = busy;
      end
   end

   // sync_writer model: done 10 cycles after sync, optional early pulse and cross-channel noise
   int         d_at      = -1;
   logic [3:0] d_vec     = 4'b0000;
   logic [3:0] hang_mask = 4'b0000;
   logic       noise_en  = 1'b0;
   initial begin
      sw_done = 4'b0000;
      forever begin
         @(negedge clk);
         if (rst) d_at = -1;
         else if (sw_sync != 4'b0000 && (sw_sync & hang_mask) == 4'b0000) begin
            d_at  = cyc + 10;
            d_vec = sw_sync;
         end
         @(posedge clk);
         #1;
         if (cyc == d_at || (noise_en && cyc == d_at - 9)) sw_done = d_vec;
         else sw_done = noise_en ? ~d_vec : 4'b0000;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int t;

   initial begin
      rst          = 1'b0;
      vblank_start = 1'b0;
      sync_req     = 4'b0000;
`ifdef VRAM_SYNC_WATCHDOG_EN
      err_clr      = 4'b0000;
`endif
      #2 rst = 1'b1;
      @(negedge clk);
      check("reset pending", pending, 0);
      check("reset sw_sync", sw_sync, 0);
      check("reset sw_clr_done", sw_clr_done, 0);
      check("reset src_lock", src_lock, 0);
      check("reset sync_ack", sync_ack, 0);
      check("reset busy", busy, 0);
      check("reset frame_done", frame_done, 0);
      check("reset overrun", overrun, 0);
      tick(2);
      rst = 1'b0;
      tick(2);

      // Two channels, timeline hand-derived from the 0b0101 example
      noise_en = 1'b1;
      sync_req = 4'b0001;
      tick(1);
      sync_req = 4'b0100;
      tick(1);
      sync_req = 4'b0000;
      check("pending before vblank", pending, 4'b0101);
      t = cyc;
      vblank_start = 1'b1;
      push(t + 1,  K_BUSY,  4'b0001);
      push(t + 2,  K_SYNC,  4'b0001);
      push(t + 2,  K_LOCK,  4'b0001);
      push(t + 13, K_ACK,   4'b0001);
      push(t + 13, K_CLR,   4'b0001);
      push(t + 14, K_LOCK,  4'b0000);
      push(t + 15, K_SYNC,  4'b0100);
      push(t + 15, K_LOCK,  4'b0100);
      push(t + 26, K_ACK,   4'b0100);
      push(t + 26, K_CLR,   4'b0100);
      push(t + 27, K_FRAME, 4'b0001);
      push(t + 27, K_LOCK,  4'b0000);
      push(t + 27, K_BUSY,  4'b0000);
      tick(1);
      vblank_start = 1'b0;
      tick(30);
      noise_en = 1'b0;
      check("pending after frame", pending, 0);

      // Request colliding with the snapshot edge stays for the next frame
      sync_req = 4'b0001;
      tick(1);
      sync_req = 4'b0010;
      vblank_start = 1'b1;
      t = cyc;
      expect_frame(t, 4'b0001);
      tick(1);
      sync_req = 4'b0000;
      vblank_start = 1'b0;
      check("pending right after snapshot", pending, 4'b0010);
      tick(20);
      check("pending carried to next frame", pending, 4'b0010);
      t = cyc;
      vblank_start = 1'b1;
      expect_frame(t, 4'b0010);
      tick(1);
      vblank_start = 1'b0;
      tick(20);

      // vblank_start during WAIT only raises overrun
      sync_req = 4'b1000;
      tick(1);
      sync_req = 4'b0000;
      t = cyc;
      vblank_start = 1'b1;
      expect_frame(t, 4'b1000);
      tick(1);
      vblank_start = 1'b0;
      tick(4);
      push(cyc, K_OVR, 4'b0001);
      vblank_start = 1'b1;
      tick(1);
      vblank_start = 1'b0;
      tick(20);

      // vblank_start with nothing pending does nothing
      vblank_start = 1'b1;
      tick(1);
      vblank_start = 1'b0;
      check("busy idle vblank", busy, 0);
      tick(5);
      check("busy idle vblank later", busy, 0);

      // Asynchronous reset during WAIT of channel 2
      sync_req = 4'b0100;
      tick(1);
      sync_req = 4'b0000;
      t = cyc;
      vblank_start = 1'b1;
      push(t + 1, K_BUSY, 4'b0001);
      push(t + 2, K_SYNC, 4'b0100);
      push(t + 2, K_LOCK, 4'b0100);
      tick(1);
      vblank_start = 1'b0;
      sync_req = 4'b0001;
      tick(1);
      sync_req = 4'b0000;
      tick(4);
      check("lock before reset", src_lock, 4'b0100);
      push(cyc, K_LOCK, 4'b0000);
      push(cyc, K_BUSY, 4'b0000);
      #1 rst = 1'b1;
      #1;
      check("async reset src_lock", src_lock, 0);
      check("async reset busy", busy, 0);
      check("async reset pending", pending, 0);
      tick(2);
      rst = 1'b0;
      tick(2);
      check("pending after reset", pending, 0);
      vblank_start = 1'b1;
      tick(1);
      vblank_start = 1'b0;
      tick(3);
      check("busy after reset vblank", busy, 0);
      sync_req = 4'b0010;
      tick(1);
      sync_req = 4'b0000;
      t = cyc;
      vblank_start = 1'b1;
      expect_frame(t, 4'b0010);
      tick(1);
      vblank_start = 1'b0;
      tick(20);

`ifdef VRAM_SYNC_WATCHDOG_EN
      // Channel 3 never finishes; watchdog retires it after 16 WAIT cycles
      hang_mask = 4'b1000;
      sync_req = 4'b1000;
      tick(1);
      sync_req = 4'b0000;
      t = cyc;
      vblank_start = 1'b1;
      push(t + 1,  K_BUSY,  4'b0001);
      push(t + 2,  K_SYNC,  4'b1000);
      push(t + 2,  K_LOCK,  4'b1000);
      push(t + 19, K_CLR,   4'b1000);
      push(t + 20, K_FRAME, 4'b0001);
      push(t + 20, K_LOCK,  4'b0000);
      push(t + 20, K_BUSY,  4'b0000);
      tick(1);
      vblank_start = 1'b0;
      tick(22);
      check("timeout_err set", timeout_err, 4'b1000);
      err_clr = 4'b1000;
      tick(1);
      err_clr = 4'b0000;
      check("timeout_err cleared", timeout_err, 0);
      hang_mask = 4'b0000;
      tick(2);
`endif

      tick(5);
      while (exp_q.size() > 0) begin
         ev_t e;
         e = exp_q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL missing %s: got no event, required %b at cycle %0d", kname(e.kind), e.val, e.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
